// File: rtl/sram_rr_arbiter_if.sv
// rtl/sram_rr_arbiter_if.sv - requester-side command/response bundle for the SRAM arbiter
interface sram_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_last;

  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - round-robin burst arbiter sharing one registered-read SRAM
module sram_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_rr_arbiter_if.slave      req_if,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic                  sram_wr_en_o,
  output logic                  sram_rd_en_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic                  busy_o
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic                  sram_wr_en_q, sram_wr_en_d;
  logic                  sram_rd_en_q, sram_rd_en_d;
  logic [DATA_WIDTH-1:0] sram_wdata_q, sram_wdata_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [PTR_W-1:0]      rd_owner_q, rd_owner_d;
  logic                  rd_last_q, rd_last_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic                  rsp_last_q, rsp_last_d;

  logic                  gnt_found;
  logic [PTR_W-1:0]      gnt_idx, cand;
  logic [NUM_REQ-1:0]    ready;
  logic                  accept;
  logic [PTR_W-1:0]      sel;
  logic                  beat_we, beat_last;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [LEN_WIDTH-1:0]  beat_len;
  logic [DATA_WIDTH-1:0] beat_wdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  // Cyclic search for the first valid requester starting at rr_ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_if.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
      cand = ptr_inc(cand);
    end
  end

  always_comb begin
    ready = '0;
    if (rst_n) begin
      if (state_q == IDLE) begin
        if (gnt_found) ready[gnt_idx] = 1'b1;
      end else begin
        ready[owner_q] = 1'b1;
      end
    end
  end

  assign accept     = |(req_if.req_valid & ready);
  assign sel        = (state_q == IDLE) ? gnt_idx : owner_q;
  assign beat_len   = req_if.req_len[gnt_idx*LEN_WIDTH +: LEN_WIDTH];
  assign beat_we    = (state_q == IDLE) ? req_if.req_we[gnt_idx] : we_q;
  assign beat_addr  = (state_q == IDLE) ? req_if.req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH]
                                        : cur_addr_q;
  assign beat_last  = (state_q == IDLE) ? (beat_len == '0) : (remaining_q == LEN_WIDTH'(1));
  assign beat_wdata = req_if.req_wdata[sel*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    we_d        = we_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (beat_last) begin
            rr_ptr_d = ptr_inc(gnt_idx);
          end else begin
            state_d     = BURST;
            owner_d     = gnt_idx;
            cur_addr_d  = beat_addr + 1'b1;
            remaining_d = beat_len;
            we_d        = beat_we;
          end
        end
        default: begin
          cur_addr_d  = cur_addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (beat_last) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_inc(owner_q);
          end
        end
      endcase
    end
  end

  // Command stage is the SRAM cycle; response stage follows the registered read by one cycle.
  always_comb begin
    sram_wr_en_d = accept & beat_we;
    sram_rd_en_d = accept & ~beat_we;
    sram_addr_d  = accept ? beat_addr : sram_addr_q;
    sram_wdata_d = (accept && beat_we) ? beat_wdata : sram_wdata_q;
    rd_pend_d    = accept & ~beat_we;
    rd_owner_d   = sel;
    rd_last_d    = beat_last;
    rsp_valid_d  = '0;
    if (rd_pend_q) rsp_valid_d[rd_owner_q] = 1'b1;
    rsp_last_d   = rd_pend_q & rd_last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      we_q         <= 1'b0;
      sram_addr_q  <= '0;
      sram_wr_en_q <= 1'b0;
      sram_rd_en_q <= 1'b0;
      sram_wdata_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= '0;
      rd_last_q    <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      we_q         <= we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wr_en_q <= sram_wr_en_d;
      sram_rd_en_q <= sram_rd_en_d;
      sram_wdata_q <= sram_wdata_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      rd_last_q    <= rd_last_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_last_q   <= rsp_last_d;
    end
  end

  assign req_if.req_ready = ready;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_data  = sram_rdata_i;
  assign req_if.rsp_last  = rsp_last_q;
  assign sram_addr_o      = sram_addr_q;
  assign sram_wr_en_o     = sram_wr_en_q;
  assign sram_rd_en_o     = sram_rd_en_q;
  assign sram_wdata_o     = sram_wdata_q;
  assign busy_o           = (state_q == BURST);
endmodule
